// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// mult/multu/div/divu take a fixed number of cycles with busy asserted;
// mthi/mtlo are single-cycle writes. A flushed request never touches HI/LO.
module muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_n, hi_n_d, lo_n, lo_n_d;
  logic          commit_en, commit_en_d;

  // Operand views shared by the arithmetic in the next-state logic
  logic signed [63:0] sa, sb, sbd;
  logic        [63:0] prod_s, prod_u;
  logic        [31:0] bd;

  // Divide-by-zero substitutes a divisor of 1 so the datapath never produces X;
  // the result is discarded via commit_en. 64-bit signed division makes
  // 0x80000000 / -1 yield 0x80000000 after truncation without overflow.
  always_comb begin
    bd     = (b == '0) ? 32'd1 : b;
    sa     = {{32{a[31]}}, a};
    sb     = {{32{b[31]}}, b};
    sbd    = {{32{bd[31]}}, bd};
    prod_s = sa * sb;
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // Next-state, counter, pending-result and HI/LO update logic
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    hi_d        = hi_q;
    lo_d        = lo_q;
    hi_n_d      = hi_n;
    lo_n_d      = lo_n;
    commit_en_d = commit_en;
    unique case (state)
      IDLE: begin
        if (start && !flush) begin
          case (op)
            OP_MULT: begin
              hi_n_d      = prod_s[63:32];
              lo_n_d      = prod_s[31:0];
              commit_en_d = 1'b1;
              cnt_d       = CW'(MULT_CYCLES);
              state_d     = RUN;
            end
            OP_MULTU: begin
              hi_n_d      = prod_u[63:32];
              lo_n_d      = prod_u[31:0];
              commit_en_d = 1'b1;
              cnt_d       = CW'(MULT_CYCLES);
              state_d     = RUN;
            end
            OP_DIV: begin
              hi_n_d      = 32'(sa % sbd);
              lo_n_d      = 32'(sa / sbd);
              commit_en_d = (b != '0);
              cnt_d       = CW'(DIV_CYCLES);
              state_d     = RUN;
            end
            OP_DIVU: begin
              hi_n_d      = a % bd;
              lo_n_d      = a / bd;
              commit_en_d = (b != '0);
              cnt_d       = CW'(DIV_CYCLES);
              state_d     = RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt <= CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (commit_en) begin
            hi_d = hi_n;
            lo_d = lo_n;
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_n      <= '0;
      lo_n      <= '0;
      commit_en <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_n      <= hi_n_d;
      lo_n      <= lo_n_d;
      commit_en <= commit_en_d;
    end
  end

  assign busy = (state == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
